// File: rtl/bus_slave_pkg.sv
// Shared definitions for the burst SRAM bus slave: FSM state encoding and bus field widths.
package bus_slave_pkg;

  localparam int DATA_W  = 32;
  localparam int BE_W    = 4;
  localparam int BURST_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WRITE     = 3'd1,
    READ_WAIT = 3'd2,
    READ      = 3'd3,
    RD_END    = 3'd4,
    ERR       = 3'd5
  } state_t;

endpackage

// File: rtl/bus_slave_sram_bank.sv
// Single-port word SRAM with per-byte write enables and a one-cycle registered read port.
module bus_slave_sram_bank
  import bus_slave_pkg::*;
#(
  parameter int ADDR_BITS = 9
) (
  input  logic                 clock,
  input  logic                 wr_en,
  input  logic [BE_W-1:0]      byte_en,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_W-1:0]    wr_data,
  output logic [DATA_W-1:0]    rd_data
);

  localparam int WORDS = 1 << ADDR_BITS;

  logic [DATA_W-1:0] mem [WORDS];

  // Read data only updates on rd_en so a stalled read beat keeps its word.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (byte_en[i]) mem[addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
    if (rd_en) rd_data <= mem[addr];
  end

endmodule

// File: rtl/bus_burst_sram_slave.sv
// Burst bus slave in front of a local SRAM window: address decode, write/read burst FSM,
// error response, and zero-gated outputs suitable for OR-combining onto the shared bus.
module bus_burst_sram_slave
  import bus_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h5000_0000,
  parameter int          ADDR_BITS    = 9
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               begin_transactionIN,
  input  logic [DATA_W-1:0]  address_dataIN,
  input  logic [BE_W-1:0]    byte_enableIN,
  input  logic [BURST_W-1:0] burst_sizeIN,
  input  logic               read_n_writeIN,
  input  logic               data_validIN,
  input  logic               end_transactionIN,
  input  logic               busyIN,
  output logic [DATA_W-1:0]  address_dataOUT,
  output logic               data_validOUT,
  output logic               end_transactionOUT,
  output logic               busyOUT,
  output logic               errorOUT
);

  localparam int WORDS = 1 << ADDR_BITS;
  localparam int CNT_W = BURST_W + 1;

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BE_W-1:0]      be_q, be_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 end_q, end_d;
  logic                 err_q, err_d;

  logic [ADDR_BITS-1:0] word_index;
  logic [31:0]          last_index;
  logic                 hit, misaligned, overrun;

  logic                 sram_we, sram_re;
  logic [ADDR_BITS-1:0] sram_addr;
  logic [DATA_W-1:0]    sram_rdata;

  assign word_index = address_dataIN[ADDR_BITS+1:2];
  assign hit        = address_dataIN[31:ADDR_BITS+2] == BASE_ADDRESS[31:ADDR_BITS+2];
  assign misaligned = address_dataIN[1:0] != 2'b00;
  assign last_index = 32'(word_index) + 32'(burst_sizeIN);
  assign overrun    = last_index > 32'(WORDS - 1);

  // cnt holds beats still owed (burst+1 at start); prefetch of ptr+1 keeps read beats back-to-back.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    be_d      = be_q;
    sram_we   = 1'b0;
    sram_re   = 1'b0;
    sram_addr = ptr_q;

    case (state_q)
      IDLE: begin
        if (begin_transactionIN && hit) begin
          if (misaligned || overrun) begin
            state_d = ERR;
          end else begin
            ptr_d   = word_index;
            cnt_d   = {1'b0, burst_sizeIN} + CNT_W'(1);
            be_d    = byte_enableIN;
            state_d = read_n_writeIN ? READ_WAIT : WRITE;
          end
        end
      end
      WRITE: begin
        if (data_validIN && cnt_q != '0) begin
          sram_we = 1'b1;
          ptr_d   = ptr_q + ADDR_BITS'(1);
          cnt_d   = cnt_q - CNT_W'(1);
        end
        if (end_transactionIN) state_d = IDLE;
      end
      READ_WAIT: begin
        sram_re = 1'b1;
        state_d = READ;
      end
      READ: begin
        if (end_transactionIN) begin
          state_d = IDLE;
        end else if (!busyIN) begin
          if (cnt_q == CNT_W'(1)) begin
            state_d = RD_END;
          end else begin
            ptr_d     = ptr_q + ADDR_BITS'(1);
            cnt_d     = cnt_q - CNT_W'(1);
            sram_addr = ptr_q + ADDR_BITS'(1);
            sram_re   = 1'b1;
          end
        end
      end
      RD_END:  state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    valid_d = state_d == READ;
    busy_d  = state_d == READ_WAIT;
    end_d   = (state_d == RD_END) || (state_d == ERR);
    err_d   = state_d == ERR;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      be_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      end_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      be_q    <= be_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      end_q   <= end_d;
      err_q   <= err_d;
    end
  end

  bus_slave_sram_bank #(
    .ADDR_BITS(ADDR_BITS)
  ) u_bank (
    .clock   (clock),
    .wr_en   (sram_we),
    .byte_en (be_q),
    .rd_en   (sram_re),
    .addr    (sram_addr),
    .wr_data (address_dataIN),
    .rd_data (sram_rdata)
  );

  assign address_dataOUT    = valid_q ? sram_rdata : '0;
  assign data_validOUT      = valid_q;
  assign end_transactionOUT = end_q;
  assign busyOUT            = busy_q;
  assign errorOUT           = err_q;

endmodule

// File: tb/tb_bus_burst_sram_slave.sv
// Self-checking bench for bus_burst_sram_slave: a word model of the SRAM feeds a queue of
// expected read beats that is drained as the slave presents data.
module tb_bus_burst_sram_slave;

  localparam logic [31:0] BASE = 32'h5000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        begin_transactionIN;
  logic [31:0] address_dataIN;
  logic [3:0]  byte_enableIN;
  logic [7:0]  burst_sizeIN;
  logic        read_n_writeIN;
  logic        data_validIN;
  logic        end_transactionIN;
  logic        busyIN;
  logic [31:0] address_dataOUT;
  logic        data_validOUT;
  logic        end_transactionOUT;
  logic        busyOUT;
  logic        errorOUT;

  int          total = 0;
  int          bad = 0;
  logic [31:0] model [512];
  logic [31:0] expq [$];
  logic [31:0] wdata [8];

  always #5 clock = ~clock;

  bus_burst_sram_slave #(
    .BASE_ADDRESS(BASE),
    .ADDR_BITS   (9)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .begin_transactionIN(begin_transactionIN),
    .address_dataIN     (address_dataIN),
    .byte_enableIN      (byte_enableIN),
    .burst_sizeIN       (burst_sizeIN),
    .read_n_writeIN     (read_n_writeIN),
    .data_validIN       (data_validIN),
    .end_transactionIN  (end_transactionIN),
    .busyIN             (busyIN),
    .address_dataOUT    (address_dataOUT),
    .data_validOUT      (data_validOUT),
    .end_transactionOUT (end_transactionOUT),
    .busyOUT            (busyOUT),
    .errorOUT           (errorOUT)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] flags();
    return {28'd0, data_validOUT, busyOUT, end_transactionOUT, errorOUT};
  endfunction

  task automatic idleInputs();
    begin_transactionIN = 1'b0;
    address_dataIN      = '0;
    byte_enableIN       = '0;
    burst_sizeIN        = '0;
    read_n_writeIN      = 1'b0;
    data_validIN        = 1'b0;
    end_transactionIN   = 1'b0;
    busyIN              = 1'b0;
  endtask

  // Leaves the bench in cycle 0 with begin asserted.
  task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] be,
                               input logic [7:0] burst, input logic rnw);
    @(posedge clock); #1;
    begin_transactionIN = 1'b1;
    address_dataIN      = addr;
    byte_enableIN       = be;
    burst_sizeIN        = burst;
    read_n_writeIN      = rnw;
  endtask

  task automatic writeBurst(input logic [31:0] addr, input logic [3:0] be,
                            input logic [7:0] burst, input int nbeats);
    int idx;
    idx = int'((addr - BASE) >> 2);
    applyStimulus(addr, be, burst, 1'b0);
    for (int i = 0; i < nbeats; i++) begin
      @(posedge clock); #1;
      begin_transactionIN = 1'b0;
      data_validIN        = 1'b1;
      address_dataIN      = wdata[i];
      end_transactionIN   = (i == nbeats - 1);
      if (i <= int'(burst)) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) model[idx+i][8*b +: 8] = wdata[i][8*b +: 8];
        end
      end
      @(negedge clock);
      if (i == 0) checkOutput("wr_quiet", flags(), 32'd0);
    end
    @(posedge clock); #1;
    idleInputs();
  endtask

  task automatic readBurst(input logic [31:0] addr, input logic [7:0] burst,
                           input int stall_beat, input int stall_cycles,
                           input int exp_first, input int exp_end);
    int idx, beats, stalls, first, endc;
    idx = int'((addr - BASE) >> 2);
    for (int i = 0; i <= int'(burst); i++) expq.push_back(model[idx+i]);
    applyStimulus(addr, 4'hF, burst, 1'b1);
    beats = 0; stalls = 0; first = -1; endc = -1;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) begin
        @(posedge clock); #1;
        begin_transactionIN = 1'b0;
        busyIN = (c >= 2) && (beats == stall_beat - 1) && (stalls < stall_cycles);
      end
      @(negedge clock);
      if (c == 1) checkOutput("rd_wait_busy", 32'(busyOUT), 32'd1);
      if (data_validOUT) begin
        if (first < 0) first = c;
        if (expq.size() == 0) begin
          checkOutput("rd_extra_beat", 32'(expq.size()), 32'd1);
        end else begin
          checkOutput("rd_data", address_dataOUT, expq[0]);
          if (busyIN) stalls++;
          else begin
            void'(expq.pop_front());
            beats++;
          end
        end
      end else begin
        checkOutput("rd_gate", address_dataOUT, 32'd0);
      end
      if (end_transactionOUT) begin
        endc = c;
        break;
      end
    end
    checkOutput("rd_first", 32'(first), 32'(exp_first));
    checkOutput("rd_end", 32'(endc), 32'(exp_end));
    checkOutput("rd_beats", 32'(beats), 32'(int'(burst) + 1));
    checkOutput("rd_no_err", 32'(errorOUT), 32'd0);
    expq.delete();
    @(posedge clock); #1;
    idleInputs();
  endtask

  task automatic errCheck(input logic [31:0] addr, input logic [7:0] burst, input logic exp_err);
    applyStimulus(addr, 4'hF, burst, 1'b1);
    @(negedge clock);
    checkOutput("err_c0", flags(), 32'd0);
    @(posedge clock); #1;
    idleInputs();
    @(negedge clock);
    checkOutput("err_c1", flags(), {30'd0, exp_err, exp_err});
    @(posedge clock); #1;
    @(negedge clock);
    checkOutput("err_c2", flags(), 32'd0);
  endtask

  task automatic resetMidRead();
    applyStimulus(BASE + 32'h10, 4'hF, 8'd3, 1'b1);
    @(posedge clock); #1;
    begin_transactionIN = 1'b0;
    repeat (2) begin
      @(posedge clock); #1;
    end
    @(negedge clock);
    checkOutput("rst_pre_valid", 32'(data_validOUT), 32'd1);
    #1 reset = 1'b1;
    #1;
    checkOutput("rst_flags", flags(), 32'd0);
    checkOutput("rst_data", address_dataOUT, 32'd0);
    @(posedge clock); #2;
    reset = 1'b0;
    @(negedge clock);
    checkOutput("rst_after", flags(), 32'd0);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    idleInputs();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_flags", flags(), 32'd0);
    checkOutput("reset_data", address_dataOUT, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("post_reset_flags", flags(), 32'd0);

    wdata[0] = 32'h1111_1111; wdata[1] = 32'h2222_2222;
    wdata[2] = 32'h3333_3333; wdata[3] = 32'h4444_4444;
    writeBurst(BASE + 32'h10, 4'hF, 8'd3, 4);
    readBurst(BASE + 32'h10, 8'd3, 0, 0, 2, 6);

    wdata[0] = 32'h0000_0000;
    writeBurst(BASE + 32'h50, 4'hF, 8'd0, 1);
    wdata[0] = 32'hAABB_CCDD;
    writeBurst(BASE + 32'h50, 4'b0101, 8'd0, 1);
    readBurst(BASE + 32'h50, 8'd0, 0, 0, 2, 3);

    readBurst(BASE + 32'h10, 8'd2, 2, 2, 2, 7);

    errCheck(BASE + 32'h2, 8'd0, 1'b1);
    errCheck(BASE + 32'h7FC, 8'd1, 1'b1);
    errCheck(32'h6000_0000, 8'd0, 1'b0);

    wdata[0] = 32'hCAFE_F00D;
    writeBurst(BASE + 32'h7FC, 4'hF, 8'd0, 1);
    readBurst(BASE + 32'h7FC, 8'd0, 0, 0, 2, 3);

    wdata[0] = 32'hA5A5_A5A5; wdata[1] = 32'h5A5A_5A5A; wdata[2] = 32'h0F0F_0F0F;
    writeBurst(BASE + 32'h14, 4'hF, 8'd0, 3);
    readBurst(BASE + 32'h14, 8'd1, 0, 0, 2, 4);

    resetMidRead();
    readBurst(BASE + 32'h50, 8'd0, 0, 0, 2, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
